// File: rtl/alu_muldiv_seq.sv
// Iterative MUL/DIVU/REMU sequencer that steps the shared ALU through
// 32 add or subtract iterations behind a start/busy/done handshake.
module alu_muldiv_seq #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] result,
  output logic [BIT_WIDTH-1:0] alu_in1,
  output logic [BIT_WIDTH-1:0] alu_in2,
  output logic [3:0]           alu_op,
  input  logic [BIT_WIDTH-1:0] alu_out
);
  localparam int W = BIT_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_RSV  = 2'd3;

  state_t       state;
  logic [4:0]   cnt;
  logic [1:0]   opr;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic [W-1:0] acc;
  logic [W-1:0] divisor;
  logic [W-1:0] q;
  logic [W-1:0] rem;

  logic [W:0]   sh;
  logic         ge;
  logic [W-1:0] acc_n;
  logic [W-1:0] rem_n;
  logic [W-1:0] q_n;

  // sh[W] set means the shifted remainder already exceeds any divisor
  always_comb begin
    sh      = {rem, q[W-1]};
    ge      = sh[W] | (sh[W-1:0] >= divisor);
    acc_n   = mplier[0] ? alu_out : acc;
    rem_n   = ge ? alu_out : sh[W-1:0];
    q_n     = {q[W-2:0], ge};
    alu_in1 = '0;
    alu_in2 = '0;
    alu_op  = ALU_ADD;
    if (state == RUN) begin
      if (opr == OP_MUL) begin
        alu_in1 = acc;
        alu_in2 = mcand;
      end else begin
        alu_in1 = divisor;
        alu_in2 = sh[W-1:0];
        alu_op  = ALU_SUB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      opr     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      divisor <= '0;
      q       <= '0;
      rem     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
            divisor <= b;
            q       <= a;
            rem     <= '0;
            opr     <= op;
            cnt     <= '0;
            busy    <= 1'b1;
            if (op == OP_RSV) begin
              result <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end else if (op != OP_MUL && b == '0) begin
              result <= (op == OP_DIVU) ? '1 : a;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (opr == OP_MUL) begin
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            rem <= rem_n;
            q   <= q_n;
          end
          if (cnt == 5'd31) begin
            state <= DONE;
            done  <= 1'b1;
            if (opr == OP_MUL)
              result <= acc_n;
            else if (opr == OP_DIVU)
              result <= q_n;
            else
              result <= rem_n;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Iterative multiply/divide sequencer for the multi-cycle RV32E core. Executes MUL, DIVU and REMU by stepping the shared 32-bit ALU through 32 add or subtract iterations, with a start/busy/done handshake toward the core's control FSM. It drives the ALU operand and opcode inputs, so the ALU needs no extra multiplier or divider hardware. It sits beside the ALU in the execute stage, and the core muxes the ALU inputs to this block while `busy` is high.

## Interface
- `BIT_WIDTH`, 32, datapath width. Only 32 is supported, because the iteration count is fixed at 32.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  2'b00 MUL (low 32 bits of the product), 2'b01 DIVU, 2'b10 REMU, 2'b11 reserved
- `a`  in  32  multiplicand / dividend; captured when `start` is accepted
- `b`  in  32  multiplier / divisor; captured when `start` is accepted
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle
- `result`  out  32  registered result; held until the next accepted `start`
- `alu_in1`  out  32  to ALU `in1`
- `alu_in2`  out  32  to ALU `in2`
- `alu_op`  out  4  to ALU `opcode`
- `alu_out`  in  32  from ALU `out` (combinational)

## Operation
- ALU opcodes used:
  - ADD 4'b0000: out = in1 + in2.
  - SUB 4'b0001: out = in2 − in1. Note the operand order.
- States:
  - IDLE: `start` → RUN. If DIVU/REMU with `b`==0, or `op`==2'b11, go → DONE instead.
  - RUN: 32 iterations, with a 5-bit counter 0..31. At count 31 go → DONE.
  - DONE: `done`=1, then → IDLE.
- On acceptance, load the internal registers:
  - mcand=a, mplier=b, acc=0, divisor=b, q=a, rem=0.
- MUL iteration:
  - alu_in1=acc, alu_in2=mcand, alu_op=ADD.
  - If mplier[0], acc←alu_out.
  - mcand←mcand<<1, mplier←mplier>>1.
  - Result = acc; wraps mod 2^32.
- DIVU/REMU iteration (restoring):
  - sh = {rem, q[31]}, 33 bits.
  - alu_in1=divisor, alu_in2=sh[31:0], alu_op=SUB.
  - ge = sh[32] | (sh[31:0] ≥ divisor), using a local unsigned compare.
  - If ge: rem←alu_out, qbit=1. Else: rem←sh[31:0], qbit=0.
  - q←{q[30:0], qbit}.
  - Result = q for DIVU, rem for REMU.
- Divide by zero (no iterations):
  - DIVU result = 32'hFFFFFFFF.
  - REMU result = a.
- Reserved `op`: result = 0, via the one-cycle path.
- `start` while not IDLE is ignored; inputs are not re-captured.
- In IDLE and DONE: alu_in1=0, alu_in2=0, alu_op=ADD.

## Timing
- Reset: state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0, and all internal registers 0.
- `rst` mid-operation aborts at the next edge. No `done` is produced, and `result` is cleared.
- Normal latency, with `start` high in cycle 0 (IDLE):
  - RUN occupies cycles 1–32.
  - `done`=1 and `result` valid in cycle 33.
  - IDLE in cycle 34. A new `start` may be accepted in cycle 34.
- Fast path (div-by-zero or reserved op): `done` in cycle 1, IDLE in cycle 2.
- `busy`=1 exactly in the RUN and DONE cycles. `done` is never high for two consecutive cycles.
- `result` updates only at the RUN→DONE or IDLE→DONE transition.
- ALU outputs are combinational from state and registers. `alu_out` is consumed in the same cycle, so the ALU is purely combinational.

## Test plan
- MUL a=7, b=6, `start` in cycle 0 → `done` in cycle 33 with result=42. `alu_op`=0000 throughout RUN.
- MUL a=32'hFFFFFFFF, b=32'hFFFFFFFF → result=1. Then MUL a=32'h80000000, b=2 → result=0 (wrap).
- DIVU a=100, b=7 → result=14; REMU with the same operands → result=2. `alu_op`=0001 throughout RUN; `done` in cycle 33.
- 33-bit case: DIVU a=32'hFFFFFFFF, b=32'h80000001 → result=1; REMU → 32'h7FFFFFFE.
- Divide by zero: DIVU a=5, b=0 → `done` in cycle 1, result=32'hFFFFFFFF. REMU a=5, b=0 → result=5. Reserved `op` → result=0 in cycle 1.
- Handshake and reset:
  - `start` pulsed again in cycle 10 with different operands → ignored; the first result is still delivered in cycle 33.
  - `rst` in cycle 15 of a DIVU → IDLE next cycle; `busy`=0, `done` never asserts, result=0; a subsequent op completes correctly.
